gpio_tx_arbiter: RTL

GPIO_TX_ARBITER -- requirements
Module: gpio_tx_arbiter

---
 rtl/gpio_tx_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/gpio_tx_arbiter.sv
// Round-robin packer of processor words / keyboard bytes into 4-word frames for the GPIO link.
// Latency: grant 1 cycle after valid in IDLE; data_ready 1 cycle after the 4th beat or the flush point.
// Backpressure: only the owner sees ready, and only in COLLECT; SEND waits for a link_done rising edge or times out.
module gpio_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned FLUSH_CYCLES   = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         p_valid,
    input  logic [31:0]  p_data,
    output logic         p_ready,
    input  logic         k_valid,
    input  logic [7:0]   k_data,
    output logic         k_ready,
    input  logic         link_done,
    output logic         data_ready,
    output logic [127:0] message_out,
    output logic         owner,
    output logic         timeout_err,
    output logic [15:0]  frames_sent
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_t;

    state_t        state, state_nxt;
    logic          last_served;
    logic          link_done_q;
    logic [1:0]    count;
    logic [FW-1:0] idle_cnt;
    logic [TW-1:0] tmo_cnt;

    logic          grant_k, beat, link_rise, complete, timeout, flush;
    logic [31:0]   beat_word;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_k   = k_valid && (!p_valid || !last_served);
        beat      = owner ? k_valid : p_valid;
        beat_word = owner ? {24'h0, k_data} : p_data;
        link_rise = link_done && !link_done_q;
        complete  = 1'b0;
        timeout   = 1'b0;
        flush     = 1'b0;
        case (state)
            IDLE: begin
                if (p_valid || k_valid) state_nxt = COLLECT;
            end
            COLLECT: begin
                flush = !beat && (count != 2'd0) && (idle_cnt == FLUSH_LAST);
                if ((beat && count == 2'd3) || flush) state_nxt = SEND;
            end
            SEND: begin
                // a rising edge on the last allowed cycle still counts as completion
                complete = link_rise;
                timeout  = !link_rise && (tmo_cnt == TMO_LAST);
                if (complete || timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        p_ready = (state == COLLECT) && !owner;
        k_ready = (state == COLLECT) && owner;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_ready  <= 1'b0;
            message_out <= '0;
            owner       <= 1'b0;
            timeout_err <= 1'b0;
            frames_sent <= '0;
            last_served <= 1'b1;
            link_done_q <= 1'b0;
            count       <= '0;
            idle_cnt    <= '0;
            tmo_cnt     <= '0;
        end else begin
            link_done_q <= link_done;
            timeout_err <= timeout;
            data_ready  <= (state_nxt == SEND);
            if (state != SEND) tmo_cnt <= '0;
            case (state)
                IDLE: begin
                    if (p_valid || k_valid) begin
                        owner       <= grant_k;
                        count       <= '0;
                        idle_cnt    <= '0;
                        message_out <= '0;
                    end
                end
                COLLECT: begin
                    if (beat) begin
                        for (int i = 0; i < 4; i++) begin
                            if (count == 2'(i)) message_out[32*i +: 32] <= beat_word;
                        end
                        count    <= count + 2'd1;
                        idle_cnt <= '0;
                    end else if (count != 2'd0) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                SEND: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (complete) frames_sent <= frames_sent + 16'd1;
                    if (complete || timeout) last_served <= owner;
                end
                default: ;
            endcase
        end
    end
endmodule
